// File: rtl/bgpu_pkg.sv
// ----------------------------------------------------------------------------
// bgpu_pkg
// Shared types for the compute-unit front end.
//   - Bgpu* localparams: default sizing of a compute unit; the fetcher's
//     parameters default to these and warp_entry_t is sized by them.
//   - warp_state_e: per-warp fetch state.
//   - warp_entry_t: one row of the fetcher's per-warp table.
// ----------------------------------------------------------------------------
package bgpu_pkg;

    localparam int unsigned BgpuNumWarps       = 8;
    localparam int unsigned BgpuWarpWidth      = 32;
    localparam int unsigned BgpuPcWidth        = 32;
    localparam int unsigned BgpuFetchWidth     = 1;
    localparam int unsigned BgpuSubwarpIdWidth = (BgpuWarpWidth > 1) ? $clog2(BgpuWarpWidth) : 1;

    typedef enum logic [2:0] {
        WsFree     = 3'd0,
        WsReady    = 3'd1,
        WsFetching = 3'd2,
        WsBranch   = 3'd3,
        WsSync     = 3'd4
    } warp_state_e;

    typedef struct packed {
        warp_state_e                   state;
        logic [BgpuPcWidth-1:0]        pc;
        logic [BgpuWarpWidth-1:0]      act_mask;
        logic [BgpuSubwarpIdWidth-1:0] subwarp_id;
    } warp_entry_t;

endpackage

// File: rtl/rr_arbiter_nw.sv
// ----------------------------------------------------------------------------
// rr_arbiter_nw
// Purely combinational round-robin picker: returns the first asserted request
// found when searching upward from ptr_i, wrapping modulo NumReq.
// Ports:
//   req_i       request vector
//   ptr_i       index where the search starts (highest priority)
//   gnt_idx_o   granted index (0 when nothing is requested)
//   gnt_valid_o at least one request is asserted
// ----------------------------------------------------------------------------
module rr_arbiter_nw #(
    parameter int unsigned NumReq   = 8,
    parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0]   req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] gnt_idx_o,
    output logic                gnt_valid_o
);

    logic [IdxWidth-1:0] idx;

    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = IdxWidth'((32'(ptr_i) + i) % NumReq);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/fetcher.sv
// ----------------------------------------------------------------------------
// fetcher
// Per-warp PC/state table in front of the instruction cache. Launches warps
// into free slots, picks one READY warp per cycle round-robin for fetch, and
// updates PC/state from decoder feedback, branch resolutions and sync
// releases.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_*                      warp launch (valid/ready, pc, active mask)
//   ib_space_ok_i                per-warp instruction-buffer space available
//   ic_ready_i, fe_*             fetch request to the instruction cache
//   dec_*                        decoded-bundle feedback from the decoder
//   bru_*                        branch resolution (target pc, new mask)
//   sync_release_i               per-warp sync release
//   warp_done_o, warp_done_id_o  one-cycle pulse when a warp stops
// ----------------------------------------------------------------------------
module fetcher
    import bgpu_pkg::*;
#(
    parameter int unsigned NumWarps       = BgpuNumWarps,
    parameter int unsigned WarpWidth      = BgpuWarpWidth,
    parameter int unsigned PcWidth        = BgpuPcWidth,
    parameter int unsigned FetchWidth     = BgpuFetchWidth,
    parameter int unsigned WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1,
    parameter int unsigned SubwarpIdWidth = (WarpWidth > 1) ? $clog2(WarpWidth) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      start_valid_i,
    output logic                      start_ready_o,
    input  logic [PcWidth-1:0]        start_pc_i,
    input  logic [WarpWidth-1:0]      start_act_mask_i,

    input  logic [NumWarps-1:0]       ib_space_ok_i,

    input  logic                      ic_ready_i,
    output logic                      fe_valid_o,
    output logic [PcWidth-1:0]        fe_pc_o,
    output logic [WarpWidth-1:0]      fe_act_mask_o,
    output logic [WidWidth-1:0]       fe_warp_id_o,
    output logic [SubwarpIdWidth-1:0] fe_subwarp_id_o,
    output logic [FetchWidth-1:0]     fe_fetch_mask_o,

    input  logic                      dec_decoded_i,
    input  logic                      dec_stop_warp_i,
    input  logic                      dec_decoded_branch_i,
    input  logic                      dec_decoded_sync_i,
    input  logic [WidWidth-1:0]       dec_decoded_warp_id_i,
    input  logic [SubwarpIdWidth-1:0] dec_decoded_subwarp_id_i,
    input  logic [PcWidth-1:0]        dec_decoded_next_pc_i,

    input  logic                      bru_valid_i,
    input  logic [WidWidth-1:0]       bru_warp_id_i,
    input  logic [PcWidth-1:0]        bru_next_pc_i,
    input  logic [WarpWidth-1:0]      bru_act_mask_i,

    input  logic [NumWarps-1:0]       sync_release_i,

    output logic                      warp_done_o,
    output logic [WidWidth-1:0]       warp_done_id_o
);

    warp_entry_t         warp_q [NumWarps];
    warp_entry_t         warp_d [NumWarps];
    logic [WidWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic                done_q, done_d;
    logic [WidWidth-1:0] done_id_q, done_id_d;

    logic [NumWarps-1:0] free_vec;
    logic [NumWarps-1:0] elig_vec;
    logic [WidWidth-1:0] free_idx;
    logic [WidWidth-1:0] gnt_idx;
    logic                gnt_valid;
    logic                fe_fire;

    // Free/eligible vectors from registered state only, so a warp freed this
    // cycle is not visible to launch until the next one.
    always_comb begin
        free_vec = '0;
        elig_vec = '0;
        free_idx = '0;
        for (int w = NumWarps - 1; w >= 0; w--) begin
            free_vec[w] = (warp_q[w].state == WsFree);
            elig_vec[w] = (warp_q[w].state == WsReady) && ib_space_ok_i[w];
            if (warp_q[w].state == WsFree) begin
                free_idx = WidWidth'(w);
            end
        end
    end

    assign start_ready_o = |free_vec;

    rr_arbiter_nw #(
        .NumReq   (NumWarps),
        .IdxWidth (WidWidth)
    ) u_rr_arbiter (
        .req_i       (elig_vec),
        .ptr_i       (rr_ptr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign fe_valid_o      = gnt_valid;
    assign fe_pc_o         = warp_q[gnt_idx].pc;
    assign fe_act_mask_o   = warp_q[gnt_idx].act_mask;
    assign fe_warp_id_o    = gnt_idx;
    assign fe_subwarp_id_o = warp_q[gnt_idx].subwarp_id;
    assign fe_fetch_mask_o = '1;
    assign fe_fire         = gnt_valid && ic_ready_i;

    assign warp_done_o    = done_q;
    assign warp_done_id_o = done_id_q;

    // Each event is gated on a distinct source state, so events for different
    // warps never collide on the same table row.
    always_comb begin
        for (int w = 0; w < NumWarps; w++) begin
            warp_d[w] = warp_q[w];
        end
        rr_ptr_d  = rr_ptr_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;

        if (start_valid_i && start_ready_o) begin
            warp_d[free_idx].state      = WsReady;
            warp_d[free_idx].pc         = start_pc_i;
            warp_d[free_idx].act_mask   = start_act_mask_i;
            warp_d[free_idx].subwarp_id = '0;
        end

        if (fe_fire) begin
            warp_d[gnt_idx].state = WsFetching;
            if (gnt_idx == WidWidth'(NumWarps - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + WidWidth'(1);
            end
        end

        if (dec_decoded_i && (warp_q[dec_decoded_warp_id_i].state == WsFetching)) begin
            warp_d[dec_decoded_warp_id_i].subwarp_id = dec_decoded_subwarp_id_i;
            if (dec_stop_warp_i) begin
                warp_d[dec_decoded_warp_id_i].state = WsFree;
                done_d    = 1'b1;
                done_id_d = dec_decoded_warp_id_i;
            end else begin
                warp_d[dec_decoded_warp_id_i].pc = dec_decoded_next_pc_i;
                if (dec_decoded_sync_i) begin
                    warp_d[dec_decoded_warp_id_i].state = WsSync;
                end else if (dec_decoded_branch_i) begin
                    warp_d[dec_decoded_warp_id_i].state = WsBranch;
                end else begin
                    warp_d[dec_decoded_warp_id_i].state = WsReady;
                end
            end
        end

        if (bru_valid_i && (warp_q[bru_warp_id_i].state == WsBranch)) begin
            warp_d[bru_warp_id_i].state    = WsReady;
            warp_d[bru_warp_id_i].pc       = bru_next_pc_i;
            warp_d[bru_warp_id_i].act_mask = bru_act_mask_i;
        end

        for (int w = 0; w < NumWarps; w++) begin
            if (sync_release_i[w] && (warp_q[w].state == WsSync)) begin
                warp_d[w].state = WsReady;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < NumWarps; w++) begin
                warp_q[w] <= '{state: WsFree, pc: '0, act_mask: '0, subwarp_id: '0};
            end
            rr_ptr_q  <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            for (int w = 0; w < NumWarps; w++) begin
                warp_q[w] <= warp_d[w];
            end
            rr_ptr_q  <= rr_ptr_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

`ifndef SYNTHESIS
    // Events aimed at a warp in the wrong state are dropped by the logic above;
    // flag them so upstream protocol bugs are visible in simulation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (dec_decoded_i) begin
                assert (warp_q[dec_decoded_warp_id_i].state == WsFetching)
                else $warning("fetcher: decoded feedback ignored, warp %0d not fetching",
                              dec_decoded_warp_id_i);
            end
            if (bru_valid_i) begin
                assert (warp_q[bru_warp_id_i].state == WsBranch)
                else $warning("fetcher: branch resolution ignored, warp %0d not in branch",
                              bru_warp_id_i);
            end
            for (int w = 0; w < NumWarps; w++) begin
                if (sync_release_i[w]) begin
                    assert (warp_q[w].state == WsSync)
                    else $warning("fetcher: sync release ignored, warp %0d not in sync", w);
                end
            end
        end
    end
`endif

endmodule
